// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the ALU shift execution unit
package alu_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered barrel-shifter level, shifting by 2**STAGE when its shamt bit is set
module shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STAGE = 0,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic               in_sign,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [MODE_W-1:0]  out_mode,
  output logic               out_sign,
  output logic [TAG_W-1:0]   out_tag,
  output logic [WIDTH-1:0]   res_d
);

  localparam int N = 2 ** STAGE;

  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   shifted;
  logic               valid_d, valid_q;
  logic [WIDTH-1:0]   data_d, data_q;
  logic [SHAMT_W-1:0] shamt_d, shamt_q;
  logic [MODE_W-1:0]  mode_d, mode_q;
  logic               sign_d, sign_q;
  logic [TAG_W-1:0]   tag_d, tag_q;

  // SRA fills from the operand's original sign, carried down the pipe
  assign fill_mask = ~({WIDTH{1'b1}} >> N);

  always_comb begin
    shifted = in_data;
    if (in_shamt[STAGE]) begin
      case (in_mode)
        SLL:     shifted = in_data << N;
        SRL:     shifted = in_data >> N;
        SRA:     shifted = (in_data >> N) | (in_sign ? fill_mask : '0);
        ROL:     shifted = (in_data << N) | (in_data >> (WIDTH - N));
        ROR:     shifted = (in_data >> N) | (in_data << (WIDTH - N));
        default: shifted = in_data;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    tag_d   = tag_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = shifted;
      shamt_d = in_shamt;
      mode_d  = in_mode;
      sign_d  = in_sign;
      tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
    end
  end

  assign res_d     = shifted;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_mode  = mode_q;
  assign out_sign  = sign_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter/rotator with valid/ready handshake and global stall
module shift_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [2:0]        mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  S,
  output logic              zero,
  output logic [TAG_W-1:0]  out_tag
);

  logic stall;
  logic en;

  logic               valid0_d, valid0_q;
  logic [WIDTH-1:0]   data0_d, data0_q;
  logic [SHAMT_W-1:0] shamt0_d, shamt0_q;
  logic [MODE_W-1:0]  mode0_d, mode0_q;
  logic               sign0_d, sign0_q;
  logic [TAG_W-1:0]   tag0_d, tag0_q;
  logic               zero_d, zero_q;

  logic               valid_c [0:SHAMT_W];
  logic [WIDTH-1:0]   data_c  [0:SHAMT_W];
  logic [SHAMT_W-1:0] shamt_c [0:SHAMT_W];
  logic [MODE_W-1:0]  mode_c  [0:SHAMT_W];
  logic               sign_c  [0:SHAMT_W];
  logic [TAG_W-1:0]   tag_c   [0:SHAMT_W];
  logic [WIDTH-1:0]   last_res;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;

  // Operand capture; an idle accepting cycle loads a bubble
  always_comb begin
    valid0_d = valid0_q;
    data0_d  = data0_q;
    shamt0_d = shamt0_q;
    mode0_d  = mode0_q;
    sign0_d  = sign0_q;
    tag0_d   = tag0_q;
    if (en) begin
      valid0_d = in_valid;
      data0_d  = A;
      shamt0_d = B[SHAMT_W-1:0];
      mode0_d  = mode;
      sign0_d  = A[WIDTH-1];
      tag0_d   = in_tag;
    end
  end

  always_comb begin
    zero_d = zero_q;
    if (en) zero_d = (last_res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid0_q <= 1'b0;
      data0_q  <= '0;
      shamt0_q <= '0;
      mode0_q  <= '0;
      sign0_q  <= 1'b0;
      tag0_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid0_q <= valid0_d;
      data0_q  <= data0_d;
      shamt0_q <= shamt0_d;
      mode0_q  <= mode0_d;
      sign0_q  <= sign0_d;
      tag0_q   <= tag0_d;
      zero_q   <= zero_d;
    end
  end

  assign valid_c[0] = valid0_q;
  assign data_c[0]  = data0_q;
  assign shamt_c[0] = shamt0_q;
  assign mode_c[0]  = mode0_q;
  assign sign_c[0]  = sign0_q;
  assign tag_c[0]   = tag0_q;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    logic [WIDTH-1:0] res_w;

    shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STAGE (i)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (valid_c[i]),
      .in_data   (data_c[i]),
      .in_shamt  (shamt_c[i]),
      .in_mode   (mode_c[i]),
      .in_sign   (sign_c[i]),
      .in_tag    (tag_c[i]),
      .out_valid (valid_c[i+1]),
      .out_data  (data_c[i+1]),
      .out_shamt (shamt_c[i+1]),
      .out_mode  (mode_c[i+1]),
      .out_sign  (sign_c[i+1]),
      .out_tag   (tag_c[i+1]),
      .res_d     (res_w)
    );

    if (i == SHAMT_W - 1) begin : g_last
      assign last_res = res_w;
    end else begin : g_mid
      logic unused_res;
      assign unused_res = ^res_w;
    end
  end

  logic unused_tail;
  assign unused_tail = ^{B[WIDTH-1:SHAMT_W], shamt_c[SHAMT_W], mode_c[SHAMT_W], sign_c[SHAMT_W]};

  assign out_valid = valid_c[SHAMT_W];
  assign S         = data_c[SHAMT_W];
  assign out_tag   = tag_c[SHAMT_W];
  assign zero      = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed self-checking bench for shift_pipe at WIDTH=32
module tb_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        zero;
  logic [3:0]  out_tag;

  shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .zero      (zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] s;
    logic        z;
    logic [3:0]  tag;
  } obs_t;

  obs_t got_q[$];
  int   acc_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [31:0] op_a [16];
  logic [31:0] op_b [16];
  logic [2:0]  op_m [16];
  logic [31:0] op_s [16];
  logic        op_z [16];

  logic        d_acc, d_rdy;
  logic [31:0] d_s;
  logic [3:0]  d_tag;

  // Entered just after a falling edge; the inputs apply to the next rising edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] m, input logic [3:0] t, input logic ordy,
                       output logic acc, output logic rdy, output logic [31:0] s_seen,
                       output logic [3:0] tag_seen);
    obs_t o;
    in_valid = v; A = a; B = b; mode = m; in_tag = t; out_ready = ordy;
    #1;
    rdy      = in_ready;
    acc      = v && in_ready && rst_n;
    s_seen   = S;
    tag_seen = out_tag;
    if (acc) acc_q.push_back(cyc);
    if (out_valid && out_ready && rst_n) begin
      o.cyc = cyc; o.s = S; o.z = zero; o.tag = out_tag;
      got_q.push_back(o);
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 3'd0, 4'd0, 1'b1, d_acc, d_rdy, d_s, d_tag);
  endtask

  task automatic run_ops(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, op_a[i], op_b[i], op_m[i], 4'(i + 1), 1'b1, d_acc, d_rdy, d_s, d_tag);
    idle(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b1, 32'h0000_0001, 32'd0, 3'd0, 4'd9, 1'b1, d_acc, d_rdy, d_s, d_tag);
    cycle(1'b1, 32'h0000_0001, 32'd0, 3'd0, 4'd9, 1'b1, d_acc, d_rdy, d_s, d_tag);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (S !== 32'h0) begin n_err++; $display("FAIL reset_S got %h want 00000000", S); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", zero); end
    n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    got_q.delete(); acc_q.delete();
    idle(12);
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL reset_no_result got %0d results want 0", got_q.size()); end
  endtask

  task automatic test_modes();
    int n;
    op_a[0] = 32'h0000_0001; op_b[0] = 32'd31; op_m[0] = 3'd0; op_s[0] = 32'h8000_0000;
    op_a[1] = 32'h8000_0000; op_b[1] = 32'd4;  op_m[1] = 3'd2; op_s[1] = 32'hF800_0000;
    op_a[2] = 32'h0000_00F1; op_b[2] = 32'd4;  op_m[2] = 3'd4; op_s[2] = 32'h1000_000F;
    op_a[3] = 32'h8000_0001; op_b[3] = 32'd1;  op_m[3] = 3'd3; op_s[3] = 32'h0000_0003;
    op_a[4] = 32'hFFFF_FFFF; op_b[4] = 32'd36; op_m[4] = 3'd1; op_s[4] = 32'h0FFF_FFFF;
    got_q.delete(); acc_q.delete();
    run_ops(5);
    n_cmp++; if (got_q.size() != 5) begin n_err++; $display("FAIL modes_count got %0d want 5", got_q.size()); end
    n = (got_q.size() < 5) ? got_q.size() : 5;
    if (acc_q.size() < n) n = acc_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got_q[i].s !== op_s[i]) begin n_err++; $display("FAIL modes_S[%0d] got %h want %h", i, got_q[i].s, op_s[i]); end
      n_cmp++; if (got_q[i].tag !== 4'(i + 1)) begin n_err++; $display("FAIL modes_tag[%0d] got %0d want %0d", i, got_q[i].tag, i + 1); end
      n_cmp++; if (got_q[i].z !== 1'b0) begin n_err++; $display("FAIL modes_zero[%0d] got %b want 0", i, got_q[i].z); end
      // accepted at edge k, sampled in the first window after edge k+5
      n_cmp++; if (got_q[i].cyc - acc_q[i] != 6) begin n_err++; $display("FAIL modes_latency[%0d] got %0d want 6", i, got_q[i].cyc - acc_q[i]); end
    end
  endtask

  task automatic test_edge_modes();
    int n;
    op_a[0] = 32'hDEAD_BEEF; op_b[0] = 32'd3;  op_m[0] = 3'd6; op_s[0] = 32'hDEAD_BEEF; op_z[0] = 1'b0;
    op_a[1] = 32'h0000_0001; op_b[1] = 32'd31; op_m[1] = 3'd3; op_s[1] = 32'h8000_0000; op_z[1] = 1'b0;
    op_a[2] = 32'h0000_0001; op_b[2] = 32'd31; op_m[2] = 3'd4; op_s[2] = 32'h0000_0002; op_z[2] = 1'b0;
    op_a[3] = 32'h7000_0000; op_b[3] = 32'd8;  op_m[3] = 3'd2; op_s[3] = 32'h0070_0000; op_z[3] = 1'b0;
    op_a[4] = 32'h0000_0002; op_b[4] = 32'd2;  op_m[4] = 3'd1; op_s[4] = 32'h0000_0000; op_z[4] = 1'b1;
    op_a[5] = 32'h1234_5678; op_b[5] = 32'd0;  op_m[5] = 3'd0; op_s[5] = 32'h1234_5678; op_z[5] = 1'b0;
    op_a[6] = 32'h8000_0000; op_b[6] = 32'h20; op_m[6] = 3'd2; op_s[6] = 32'h8000_0000; op_z[6] = 1'b0;
    op_a[7] = 32'h0000_0000; op_b[7] = 32'd5;  op_m[7] = 3'd7; op_s[7] = 32'h0000_0000; op_z[7] = 1'b1;
    op_a[8] = 32'h8000_0001; op_b[8] = 32'd31; op_m[8] = 3'd2; op_s[8] = 32'hFFFF_FFFF; op_z[8] = 1'b0;
    op_a[9] = 32'h0000_00F0; op_b[9] = 32'd4;  op_m[9] = 3'd5; op_s[9] = 32'h0000_00F0; op_z[9] = 1'b0;
    got_q.delete(); acc_q.delete();
    run_ops(10);
    n_cmp++; if (got_q.size() != 10) begin n_err++; $display("FAIL edge_count got %0d want 10", got_q.size()); end
    n = (got_q.size() < 10) ? got_q.size() : 10;
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got_q[i].s !== op_s[i]) begin n_err++; $display("FAIL edge_S[%0d] got %h want %h", i, got_q[i].s, op_s[i]); end
      n_cmp++; if (got_q[i].z !== op_z[i]) begin n_err++; $display("FAIL edge_zero[%0d] got %b want %b", i, got_q[i].z, op_z[i]); end
      n_cmp++; if (got_q[i].tag !== 4'(i + 1)) begin n_err++; $display("FAIL edge_tag[%0d] got %0d want %0d", i, got_q[i].tag, i + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_s [8];
    int   idx;
    int   n;
    logic acc, rdy, ordy;
    logic [31:0] s_seen;
    logic [3:0]  t_seen;
    exp_s[0] = 32'h003; exp_s[1] = 32'h006; exp_s[2] = 32'h00C; exp_s[3] = 32'h018;
    exp_s[4] = 32'h030; exp_s[5] = 32'h060; exp_s[6] = 32'h0C0; exp_s[7] = 32'h180;
    got_q.delete(); acc_q.delete();
    idx = 0;
    for (int rel = 0; rel < 26; rel++) begin
      ordy = !(rel >= 7 && rel <= 9);
      cycle(idx < 8, 32'h0000_0003, 32'(idx), 3'd0, 4'(idx), ordy, acc, rdy, s_seen, t_seen);
      if (acc) idx++;
      if (rel >= 7 && rel <= 9) begin
        n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", rel, rdy); end
        n_cmp++; if (s_seen !== 32'h006) begin n_err++; $display("FAIL bp_S_held[%0d] got %h want 00000006", rel, s_seen); end
        n_cmp++; if (t_seen !== 4'd1) begin n_err++; $display("FAIL bp_tag_held[%0d] got %0d want 1", rel, t_seen); end
      end
    end
    n_cmp++; if (got_q.size() != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got_q.size()); end
    n = (got_q.size() < 8) ? got_q.size() : 8;
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (got_q[i].s !== exp_s[i]) begin n_err++; $display("FAIL bp_S[%0d] got %h want %h", i, got_q[i].s, exp_s[i]); end
      n_cmp++; if (got_q[i].tag !== 4'(i)) begin n_err++; $display("FAIL bp_tag[%0d] got %0d want %0d", i, got_q[i].tag, i); end
    end
  endtask

  task automatic test_reset_flight();
    logic acc, rdy;
    got_q.delete(); acc_q.delete();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0000_0001, 32'd1, 3'd0, 4'(i + 1), 1'b1, d_acc, d_rdy, d_s, d_tag);
    rst_n = 1'b0;
    cycle(1'b0, '0, '0, 3'd0, 4'd0, 1'b1, d_acc, d_rdy, d_s, d_tag);
    rst_n = 1'b1;
    acc_q.delete();
    cycle(1'b1, 32'h0000_0001, 32'd1, 3'd4, 4'hA, 1'b1, acc, rdy, d_s, d_tag);
    n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rf_in_ready got %b want 1", rdy); end
    idle(12);
    n_cmp++; if (got_q.size() != 1) begin n_err++; $display("FAIL rf_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1 && acc_q.size() >= 1) begin
      n_cmp++; if (got_q[0].s !== 32'h8000_0000) begin n_err++; $display("FAIL rf_S got %h want 80000000", got_q[0].s); end
      n_cmp++; if (got_q[0].tag !== 4'hA) begin n_err++; $display("FAIL rf_tag got %h want a", got_q[0].tag); end
      n_cmp++; if (got_q[0].cyc - acc_q[0] != 6) begin n_err++; $display("FAIL rf_latency got %0d want 6", got_q[0].cyc - acc_q[0]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; mode = '0; in_tag = '0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    test_reset();
    test_modes();
    test_edge_modes();
    test_backpressure();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter supporting logical/arithmetic shifts and rotates in both directions, with a valid/ready handshake on input and output. It supersedes the single-mode combinational left shifter as the ALU's shift execution unit. It sits between operand issue and writeback and accepts one operation per cycle. Each mux level is registered, so it closes timing at wide datapaths.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of two and at least 8.
- `TAG_W`, default 4: width of the opaque tag carried alongside each operation.
- `SHAMT_W`, default `$clog2(WIDTH)`: derived; not overridden.

Ports (clock and reset first):
- `clk`  in  1  the single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  the operation on the input bus is valid.
- `in_ready`  out  1  the unit can accept an operation this cycle.
- `A`  in  WIDTH  operand to be shifted.
- `B`  in  WIDTH  shift amount. Only `B[SHAMT_W-1:0]` is used; upper bits are ignored.
- `mode`  in  3  operation, `shift_mode_e` from the package.
- `in_tag`  in  TAG_W  tag, passed through unmodified.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  downstream accepts the result.
- `S`  out  WIDTH  result.
- `zero`  out  1  high when `S == 0`.
- `out_tag`  out  TAG_W  tag of the operation currently on `S`.

## Operation
- Modes:
  - SLL=0: shift left, zero fill.
  - SRL=1: shift right, zero fill.
  - SRA=2: shift right, fill with `A[WIDTH-1]`.
  - ROL=3: rotate left.
  - ROR=4: rotate right.
  - Codes 5–7 are illegal. They pass `A` through unchanged, with `zero` computed normally.
- Shift amount: `shamt = B[SHAMT_W-1:0]`, range 0..WIDTH-1. `shamt = 0` returns `A` in every mode.
- Datapath: SHAMT_W stages. Stage i conditionally shifts by 2^i, controlled by `shamt[i]`.
  - Each stage register holds: the partial result, the remaining `shamt` bits, `mode`, the sign bit, `tag` and a valid bit.
- Handshake:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Stall is global: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - While stalled, every stage register holds its value.
  - Bubbles are not collapsed.
- Cycles with `in_valid = 0` and `in_ready = 1` inject a bubble (valid = 0) into stage 0.
- `zero` and `out_tag` are valid only while `out_valid = 1`. Both are registered with `S` in the final stage.

## Timing
- Latency: an operation accepted at rising edge k appears with `out_valid = 1` after edge k+SHAMT_W (5 cycles at WIDTH=32), provided there are no stalls. Each cycle of stall adds one cycle.
- Throughput: one operation per cycle while `out_ready = 1`.
- `in_ready` is a combinational function of `out_valid` and `out_ready` only. There is no path from `in_valid`.
- `S`, `zero`, `out_tag` and `out_valid` are registered outputs and are held stable while stalled.
- Reset, `rst_n = 0` sampled at an edge:
  - All stage valid bits clear. `out_valid = 0`, `S = 0`, `zero = 0`, `out_tag = 0`.
  - In-flight operations are discarded.
  - `in_ready = 1` in the first cycle after reset.
- Simultaneous output transfer and input acceptance in the same cycle is legal: the pipeline advances and both happen.
- A stall arriving while a bubble is in the output stage cannot occur, because `out_valid = 0` there. No special case is needed.

## Structure
- Package `alu_pkg` adds:
  - `typedef enum logic [2:0] shift_mode_e` with values SLL, SRL, SRA, ROL, ROR.
  - Any shared width constants.
- Sub-module `shift_stage #(WIDTH, TAG_W, STAGE)`: one registered mux level. It receives the enable from the global stall and applies the 2^STAGE shift, fill or rotate for the current mode.
- `shift_pipe` instantiates `shift_stage` in a generate loop of SHAMT_W instances. It also holds the stall/ready logic and the final `zero` reduction.

## Test plan
All cases at WIDTH=32, `out_ready = 1` unless stated.
- Reset: hold `rst_n = 0` for 2 cycles with `in_valid = 1` → `out_valid = 0`, `S = 0`, `in_ready = 1`. The first result appears only for inputs accepted after reset deasserts.
- Modes: each operation is issued back to back with tags 1..5, and results return in order with latency 5:
  - SLL `0x0000_0001` by 31 → `0x8000_0000`
  - SRA `0x8000_0000` by 4 → `0xF800_0000`
  - ROR `0x0000_00F1` by 4 → `0x1000_000F`
  - ROL `0x8000_0001` by 1 → `0x0000_0003`
  - SRL `0xFFFF_FFFF` with B=36 → `0x0FFF_FFFF` (upper bits of B ignored)
- Zero flag: SRL `0x0000_0002` by 2 → `S = 0`, `zero = 1`. Shift by 0 of `0x1234_5678` → `S` unchanged, `zero = 0`.
- Backpressure: stream 8 ops, and drop `out_ready` for 3 cycles mid-stream → `in_ready = 0` for those 3 cycles, `S` and `out_tag` are held, and nothing is lost or duplicated.
- Reset mid-flight: 4 ops in flight, pulse `rst_n = 0` for 1 cycle → no result from those ops ever appears. A new op is returned 5 cycles after acceptance.
- Random: constrained-random A, B, mode (including codes 5–7) and valid/ready toggling, checked against a reference model and a tag-order scoreboard.
